// File: rtl/rr_dispatch8.sv
// rr_dispatch8 -- scheduler in front of an 8-way demultiplexer.
//
// Takes a valid/ready stream of data words and parks each accepted word in a
// one-entry output register, routed to one of 8 channels. The channel is the
// next enabled one after the round-robin pointer (mode=0) or in_dest
// (mode=1). A directed word aimed at a disabled channel is consumed and
// reported on drop instead of being held.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is combinational from the state, out_ready and chan_en.
// in_valid/in_data/in_dest/mode must stay stable while in_valid waits for
// in_ready. out_valid[sel] stays 1 with stable out_data until out_ready[sel].
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   mode, chan_en        routing mode (0 rr, 1 directed), channel enable mask
//   in_valid/in_ready    input handshake; in_data word, in_dest target
//   sel, entrada         demux select and "word held" flag (entrada is also
//                        the FSM state: 0 = EMPTY, 1 = HOLD)
//   out_valid/out_ready  per-channel one-hot handshake, out_data shared word
//   drop                 one-cycle pulse for a discarded directed word
//   stall_err            sticky, set once a word waited TIMEOUT cycles
//   sent_cnt             completed output handshakes, wraps at 16 bits
module rr_dispatch8 #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [7:0]       chan_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_dest,
    output logic [2:0]       sel,
    output logic             entrada,
    output logic [7:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic [7:0]       out_ready,
    output logic             drop,
    output logic             stall_err,
    output logic [15:0]      sent_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             drop_q, drop_d;
    logic             stall_q, stall_d;
    logic [15:0]      sent_q, sent_d;
    logic [7:0]       wait_q, wait_d;

    logic             out_fire;
    logic             accept;
    logic             drop_now;
    logic [2:0]       ptr_eff;
    logic [2:0]       rr_chan;
    logic             rr_found;
    logic [2:0]       tgt;

    always_comb begin
        out_fire = (state_q == HOLD) && out_ready[sel_q];
        // Round-robin with nothing enabled has nowhere to put a word.
        in_ready = ((state_q == EMPTY) || out_fire) && !(!mode && (chan_en == 8'h00));
        accept   = in_valid && in_ready;
        // A word loaded in the same cycle as a fire searches from the
        // pointer the fire is about to write, so rr stays fair at full rate.
        ptr_eff  = out_fire ? (sel_q + 3'd1) : ptr_q;
    end

    // First enabled channel at or after ptr_eff, wrapping modulo 8.
    always_comb begin
        rr_chan  = ptr_eff;
        rr_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!rr_found && chan_en[ptr_eff + 3'(i)]) begin
                rr_chan  = ptr_eff + 3'(i);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        tgt      = mode ? in_dest : rr_chan;
        drop_now = accept && mode && !chan_en[in_dest];
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        sent_d  = sent_q;
        wait_d  = wait_q;
        stall_d = stall_q;
        drop_d  = drop_now;

        if (out_fire) begin
            sent_d  = sent_q + 16'd1;
            ptr_d   = sel_q + 3'd1;
            state_d = EMPTY;
        end else if (state_q == HOLD) begin
            if (wait_q < TMO) begin
                wait_d = wait_q + 8'd1;
            end
        end

        // A dropped word never occupies the register; a fire in the same
        // cycle still empties it.
        if (accept && !drop_now) begin
            state_d = HOLD;
            sel_d   = tgt;
            data_d  = in_data;
            wait_d  = 8'd0;
        end

        if (wait_d == TMO) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            data_q  <= '0;
            drop_q  <= 1'b0;
            stall_q <= 1'b0;
            sent_q  <= 16'd0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
            stall_q <= stall_d;
            sent_q  <= sent_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        sel       = sel_q;
        entrada   = (state_q == HOLD);
        out_valid = entrada ? (8'd1 << sel_q) : 8'd0;
        out_data  = data_q;
        drop      = drop_q;
        stall_err = stall_q;
        sent_cnt  = sent_q;
    end

endmodule

// File: doc/rr_dispatch8.md
Name: rr_dispatch8

Overview:
- Sequential scheduler that drives an 8-way demultiplexer.
- Accepts a valid/ready input stream of data words and assigns each word to one of 8 output channels, either round-robin over the enabled channels or by an explicit destination.
- Holds each word in a one-entry output register until the selected channel accepts it.
- Exposes sel/entrada so a downstream 8-way demux can be wired directly, and also provides a one-hot per-channel valid.

Parameters:
- WIDTH, 8, data word width.
- TIMEOUT, 15, cycles a held word may wait for its channel before stall_err is set; range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = round-robin, 1 = directed; sampled only on accept.
- chan_en  input  8  per-channel enable mask for round-robin.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  input word.
- in_dest  input  3  destination channel, used when mode=1.
- sel  output  3  currently selected channel; drives the demux sel.
- entrada  output  1  1 while a word is held; drives the demux data input.
- out_valid  output  8  one-hot valid, equal to entrada routed by sel.
- out_data  output  WIDTH  held word, common to all channels.
- out_ready  input  8  per-channel ready.
- drop  output  1  one-cycle pulse when a directed word targets a disabled channel.
- stall_err  output  1  sticky; set on timeout, cleared only by reset.
- sent_cnt  output  16  count of completed output handshakes; wraps at 65535->0.

Behaviour:
- Reset (rst_n=0 at a clock edge) applies regardless of state or in-flight word:
  - state=EMPTY; held word discarded.
  - sel=0, entrada=0, out_valid=0, out_data=0.
  - rr pointer ptr=0, drop=0, stall_err=0, sent_cnt=0, wait counter=0.
- States: EMPTY (no word held) and HOLD (word held, entrada=1).
- out_fire = (state==HOLD) and out_ready[sel].
- in_ready = (state==EMPTY or out_fire) and not (mode==0 and chan_en==0).
  - in_ready is combinational from state, out_ready and chan_en.
  - In directed mode in_ready does not depend on chan_en.
- Accept (in_valid and in_ready) chooses the target channel:
  - mode=0: first c in order ptr, ptr+1, ..., ptr+7 (mod 8) with chan_en[c]=1.
  - mode=1: c=in_dest.
    - If chan_en[in_dest]=0, the word is consumed and discarded: drop=1 for the next cycle.
    - State does not enter HOLD from that word; if a fire occurred in the same cycle, state becomes EMPTY.
- On a non-dropped accept, next cycle: state=HOLD, sel=c, out_data=in_data, wait counter=0.
- Latency: a word is presented on out_valid one cycle after acceptance.
- HOLD rules:
  - sel and out_data are stable until out_fire.
  - chan_en changes do not affect a held word.
- On out_fire:
  - sent_cnt increments by 1.
  - ptr = sel+1 mod 8, updated in both modes.
  - If an accept occurs in the same cycle, the new word loads back-to-back (full throughput, 1 word/cycle). The new word's rr search uses the updated ptr, i.e. the pre-fire sel+1.
  - Otherwise state=EMPTY.
- Timeout:
  - Wait counter increments each HOLD cycle without out_fire, saturating at TIMEOUT.
  - On reaching TIMEOUT, stall_err=1.
  - The word is still held; there is no automatic flush.
- drop and out_fire in the same cycle are independent; both take effect.
- Only out_valid[sel] may be 1; out_valid=0 in EMPTY.

Test Plan:
- Reset, then mode=0, chan_en=8'hFF, all out_ready=1, stream 10 words back-to-back:
  - sel sequence 0,1,...,7,0,1; one word per cycle; sent_cnt=10.
- mode=0, chan_en=8'b1010_0100, ptr=0, 4 words:
  - sel sequence 2,5,7,2.
  - With chan_en=0, in_ready=0 and no accept.
- mode=1 with dest 3, 6, 3 and chan_en[6]=0:
  - Word to 3 delivered.
  - Word to 6 gives a drop pulse, no out_valid, sent_cnt unchanged.
  - ptr follows the delivered sel only.
- Held word on channel 4 with out_ready[4]=0 for 20 cycles, TIMEOUT=15:
  - sel/out_data stable, in_ready=0.
  - stall_err rises on the 15th wait cycle and stays set after delivery.
- Word held, then rst_n=0 for one cycle:
  - Next cycle out_valid=0, entrada=0, sent_cnt=0, stall_err=0.
  - A following word goes to channel 0 in rr mode with chan_en=8'hFF.
- sent_cnt at 16'hFFFF, deliver one word:
  - sent_cnt=0, sel and ptr update normally.
